// File: rtl/trace_capture_streamer.sv
// trace_capture_streamer: captures a SAMPLES-long burst of TDC codes into RAM on trigger and streams it to uart_tx.
// Optional 3-byte stream header (A5, SAMPLES[15:8], SAMPLES[7:0]) when TRACE_HEADER_EN is defined.
module trace_capture_streamer #(
    parameter int          SAMPLES = 2048,
    parameter int          AW      = 11,
    parameter logic [7:0]  MARKER  = 8'hFF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       trig_i,
    input  logic [7:0] sample_i,
    input  logic       mark_i,
    input  logic       send_i,
    output logic       tx_dv_o,
    output logic [7:0] tx_byte_o,
    input  logic       tx_done_i,
    output logic       busy_o,
    output logic       full_o
);
    typedef enum logic [2:0] {IDLE, CAPTURE, FULL, FETCH, STROBE, WAIT} state_t;

    localparam logic [AW-1:0] LAST = AW'(SAMPLES - 1);

    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_next;
    logic          hdr_on;
    logic          we;
    logic [7:0]    mem [0:(1<<AW)-1];

    assign we     = (state == IDLE && trig_i) || state == CAPTURE;
    assign busy_o = state inside {CAPTURE, FETCH, STROBE, WAIT};

    // RAM is deliberately left out of reset so contents survive an abort
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= mark_i ? MARKER : sample_i;
        if (state == FETCH)
            rd_data <= mem[rd_addr];
    end

`ifdef TRACE_HEADER_EN
    localparam logic [15:0] SLEN = 16'(SAMPLES);
    logic [1:0] hdr_cnt;
    logic [7:0] hdr_byte;

    assign hdr_byte = hdr_cnt == 2'd0 ? 8'hA5 : hdr_cnt == 2'd1 ? SLEN[15:8] : SLEN[7:0];
    assign tx_next  = hdr_on ? hdr_byte : rd_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_on  <= 1'b0;
            hdr_cnt <= 2'd0;
        end else if (state == FULL && send_i) begin
            hdr_on  <= 1'b1;
            hdr_cnt <= 2'd0;
        end else if (state == WAIT && tx_done_i && hdr_on) begin
            hdr_on  <= hdr_cnt != 2'd2;
            hdr_cnt <= hdr_cnt + 2'd1;
        end
    end
`else
    assign hdr_on  = 1'b0;
    assign tx_next = rd_data;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            tx_dv_o   <= 1'b0;
            tx_byte_o <= 8'h00;
            full_o    <= 1'b0;
        end else begin
            tx_dv_o <= 1'b0;
            case (state)
                IDLE: if (trig_i) begin
                    wr_addr <= AW'(1);
                    state   <= CAPTURE;
                end
                CAPTURE: if (wr_addr == LAST) begin
                    wr_addr <= '0;
                    full_o  <= 1'b1;
                    state   <= FULL;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
                FULL: if (send_i) begin
                    rd_addr <= '0;
                    state   <= FETCH;
                end
                FETCH: state <= STROBE;
                STROBE: begin
                    tx_byte_o <= tx_next;
                    tx_dv_o   <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: if (tx_done_i) begin
                    if (hdr_on) begin
                        state <= FETCH;
                    end else if (rd_addr == LAST) begin
                        full_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                        state   <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_capture_streamer.sv
// tb_trace_capture_streamer: directed table-driven bench for trace_capture_streamer with SAMPLES=16.
module tb_trace_capture_streamer;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       trig_i = 1'b0;
    logic [7:0] sample_i = 8'h00;
    logic       mark_i = 1'b0;
    logic       send_i = 1'b0;
    logic       tx_done_i = 1'b0;
    logic       tx_dv_o;
    logic [7:0] tx_byte_o;
    logic       busy_o;
    logic       full_o;

    typedef struct {
        logic [7:0] s;
        logic       m;
        logic [7:0] e;
    } vec_t;

    vec_t vec [N];
    int   passed = 0;
    int   total = 0;

    trace_capture_streamer #(.SAMPLES(N), .AW(4), .MARKER(8'hFF)) dut (
        .clk(clk), .rstn(rstn), .trig_i(trig_i), .sample_i(sample_i), .mark_i(mark_i),
        .send_i(send_i), .tx_dv_o(tx_dv_o), .tx_byte_o(tx_byte_o), .tx_done_i(tx_done_i),
        .busy_o(busy_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dv"}, tx_dv_o, 0);
        chk({tag, "_byte"}, tx_byte_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_full"}, full_o, 0);
    endtask

    // hold=1 keeps trig_i high and pokes send_i throughout the capture
    task automatic capture(input bit hold);
        @(negedge clk);
        trig_i = 1'b1;
        sample_i = vec[0].s;
        mark_i = vec[0].m;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            if (!hold) trig_i = 1'b0;
            send_i = hold;
            sample_i = vec[i].s;
            mark_i = vec[i].m;
            if (i == N - 1) begin
                chk("full_before_last", full_o, 0);
                chk("busy_capture", busy_o, 1);
            end
        end
        @(negedge clk);
        send_i = 1'b0;
        sample_i = ~vec[0].s;
        mark_i = 1'b0;
        chk("full_after_fill", full_o, 1);
        chk("busy_full", busy_o, 0);
    endtask

    task automatic stream(input int hold_idx, input int abort_idx, input bit spur);
        logic [7:0] exp [$];
        int strobes;
        int extra;
        bit got;
        strobes = 0;
`ifdef TRACE_HEADER_EN
        exp.push_back(8'hA5);
        exp.push_back(8'(N >> 8));
        exp.push_back(8'(N));
`endif
        for (int i = 0; i < N; i++) exp.push_back(vec[i].e);
        @(negedge clk);
        send_i = 1'b1;
        for (int k = 0; k < exp.size(); k++) begin
            got = 1'b0;
            for (int j = 0; j < 200 && !got; j++) begin
                @(negedge clk);
                send_i = 1'b0;
                tx_done_i = 1'b0;
                if (tx_dv_o) got = 1'b1;
                else if (spur && j == 1) tx_done_i = 1'b1;
            end
            if (!got) begin
                total++;
                $display("FAIL dv_timeout byte %0d: no strobe within 200 cycles", k);
                return;
            end
            strobes++;
            chk($sformatf("byte_%0d", k), tx_byte_o, exp[k]);
            if (k == abort_idx) begin
                rstn = 1'b0;
                #1;
                chk_reset("abort");
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            extra = 0;
            repeat (k == hold_idx ? 100 : 2) begin
                @(negedge clk);
                if (tx_dv_o) extra++;
            end
            chk($sformatf("dv_low_wait_%0d", k), extra, 0);
            chk($sformatf("byte_held_%0d", k), tx_byte_o, exp[k]);
            tx_done_i = 1'b1;
        end
        @(negedge clk);
        tx_done_i = 1'b0;
        chk("end_busy", busy_o, 0);
        chk("end_full", full_o, 0);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_dv_o) extra++;
        end
        chk("no_extra_strobe", extra, 0);
        chk("strobe_count", strobes, exp.size());
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rstn = 1'b1;

        // ramp
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'(i), m: 1'b0, e: 8'(i)};
        capture(1'b0);
        stream(-1, -1, 1'b0);

        // AES-done markers on capture cycles 5 and 6
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'h40, m: (i == 5 || i == 6), e: (i == 5 || i == 6) ? 8'hFF : 8'h40};
        capture(1'b0);
        stream(-1, -1, 1'b0);

        // trig held through CAPTURE and FULL, sample changes after fill
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'h80 + 8'(i), m: 1'b0, e: 8'h80 + 8'(i)};
        capture(1'b1);
        repeat (4) @(negedge clk);
        chk("full_trig_held", full_o, 1);
        chk("busy_trig_held", busy_o, 0);
        trig_i = 1'b0;
        stream(-1, -1, 1'b0);
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'hC0 ^ 8'(i), m: 1'b0, e: 8'hC0 ^ 8'(i)};
        capture(1'b0);
        stream(-1, -1, 1'b0);

        // reset at byte 7, then a fresh burst
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'h10 + 8'(i), m: 1'b0, e: 8'h10 + 8'(i)};
        capture(1'b0);
        stream(-1, 7, 1'b0);
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'h3C + 8'(3 * i), m: 1'b0, e: 8'h3C + 8'(3 * i)};
        capture(1'b0);
        stream(-1, -1, 1'b0);

        // slow uart at byte 3 and spurious done pulses in FULL and STROBE
        for (int i = 0; i < N; i++) vec[i] = '{s: 8'(17 * i), m: 1'b0, e: 8'(17 * i)};
        capture(1'b0);
        tx_done_i = 1'b1;
        @(negedge clk);
        tx_done_i = 1'b0;
        @(negedge clk);
        chk("full_after_spur", full_o, 1);
        chk("dv_after_spur", tx_dv_o, 0);
        stream(3, -1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
